mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, memory address width (32 locations).
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-007 SHALL have port cmd_wr  input  1  1 = single write, 0 = burst read.
REQ-008 SHALL have port cmd_addr  input  ADDR_W  start address.
REQ-009 SHALL have port cmd_len  input  ADDR_W  burst beats minus one (ignored for writes).
REQ-010 SHALL have port cmd_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rd_valid  output  1  rd_data holds a beat.
REQ-012 SHALL have port rd_ready  input  1  consumer takes beat when high with rd_valid.
REQ-013 SHALL have port rd_data  output  DATA_W  read beat, registered.
REQ-014 SHALL have port rd_last  output  1  high with the final beat of a burst.
REQ-015 SHALL have ports mem_add  output  ADDR_W, mem_in  output  DATA_W, mem_read  output  1, driving the 32x8 memory (mem_read 0 = read, 1 = write).
REQ-016 SHALL have port mem_out  input  DATA_W  combinational memory read data.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, WR, RD, DRAIN; cmd_ready SHALL equal (state == IDLE).
REQ-019 On accept with cmd_wr=1: IDLE->WR; in WR, mem_add=addr, mem_in=wdata, mem_read=1 for exactly one cycle; WR->IDLE unconditionally.
REQ-020 mem_read SHALL be 0 in every state except WR, and mem_in SHALL hold its last value outside WR.
REQ-021 On accept with cmd_wr=0: IDLE->RD with internal address=cmd_addr, beat count=cmd_len+1.
REQ-022 In RD, when output register empty or rd_ready=1, SHALL capture mem_out at current mem_add into rd_data, set rd_valid, increment address, decrement count; otherwise hold mem_add and count (stall).
REQ-023 First rd_valid SHALL rise at the second rising edge after the accepting edge (latency 2).
REQ-024 Full throughput: with rd_ready held 1, one beat per cycle, no bubbles.
REQ-025 rd_last SHALL be 1 exactly while the final beat is in rd_data.
REQ-026 After final capture RD->DRAIN; DRAIN->IDLE on the edge where rd_valid&&rd_ready; rd_valid clears on that edge.
REQ-027 rd_data/rd_valid/rd_last SHALL remain stable while rd_valid=1 and rd_ready=0.
REQ-028 Address increment SHALL wrap modulo 2^ADDR_W (31->0) unless REQ-033 applies.
REQ-029 cmd_valid outside IDLE SHALL be ignored; no command queued.
REQ-030 cmd_len=0 read SHALL produce one beat with rd_last=1.

Reset
REQ-031 While rst_n=0 (asynchronously): state=IDLE, rd_valid=0, rd_last=0, rd_data=0, mem_add=0, mem_in=0, mem_read=0, busy=0, internal count/address=0.
REQ-032 Reset mid-burst or mid-write SHALL abort immediately; no memory write SHALL occur after rst_n falls; cmd_ready=1 in the first cycle after release.

Configuration
REQ-033 Macro MEMCTRL_BOUND_CHECK_EN: when defined, SHALL add output cmd_err (1 bit, reset 0) pulsing one cycle on accepting a read with cmd_addr+cmd_len > 2^ADDR_W-1; that command is dropped and state stays IDLE; when undefined, no cmd_err port exists and reads wrap per REQ-028.

Verification
REQ-034 Write addr=5 data=0xA5 -> one cycle mem_read=1, mem_add=5, mem_in=0xA5; then read addr=5 len=0 -> rd_data=0xA5, rd_last=1.
REQ-035 Memory preloaded k at address k; read addr=1 len=3, rd_ready=1 -> rd_data 1,2,3,4 on consecutive cycles, rd_last on 4, first valid 2 cycles after accept.
REQ-036 Same burst with rd_ready low 3 cycles after beat 2 -> rd_data stays 2, mem_add stable, then 3,4 delivered, no beat lost or duplicated.
REQ-037 Read addr=30 len=3 -> without macro beats from addresses 30,31,0,1; with MEMCTRL_BOUND_CHECK_EN cmd_err pulses, no rd_valid.
REQ-038 rst_n low during beat 2 of a len=7 read -> rd_valid=0 immediately, mem_read=0, cmd_ready=1 after release.
REQ-039 cmd_valid held high during a burst -> cmd_ready=0 throughout, command accepted only on first IDLE cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Command-driven controller for a 32x8 combinational-read memory: single writes and stallable burst reads.
// Optional build macro MEMCTRL_BOUND_CHECK_EN adds cmd_err and drops read bursts that would wrap.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
`ifdef MEMCTRL_BOUND_CHECK_EN
    ,
    output logic              cmd_err
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               primed_q, primed_d;
    logic [ADDR_W-1:0]  mem_add_d;
    logic [DATA_W-1:0]  mem_in_d;
    logic               mem_read_d;
    logic [DATA_W-1:0]  rd_data_d;
    logic               rd_valid_d;
    logic               rd_last_d;
    logic               rd_ok;
    logic               advance;

`ifdef MEMCTRL_BOUND_CHECK_EN
    logic               cmd_err_d;
    logic [ADDR_W:0]    end_addr;

    // Carry out of start+len means the burst would run past the top address
    assign end_addr = {1'b0, cmd_addr} + {1'b0, cmd_len};
    assign rd_ok    = ~end_addr[ADDR_W];
`else
    assign rd_ok    = 1'b1;
`endif

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    // A beat may be captured once the address phase has had a cycle and the output slot is free
    assign advance   = primed_q && (!rd_valid || rd_ready);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        primed_d   = primed_q;
        mem_add_d  = mem_add;
        mem_in_d   = mem_in;
        mem_read_d = 1'b0;
        rd_data_d  = rd_data;
        rd_valid_d = rd_valid;
        rd_last_d  = rd_last;
`ifdef MEMCTRL_BOUND_CHECK_EN
        cmd_err_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_wr) begin
                        state_d    = WR;
                        mem_add_d  = cmd_addr;
                        mem_in_d   = cmd_wdata;
                        mem_read_d = 1'b1;
                    end else if (rd_ok) begin
                        state_d   = RD;
                        mem_add_d = cmd_addr;
                        cnt_d     = CNT_W'(cmd_len) + CNT_W'(1);
                        primed_d  = 1'b0;
                    end else begin
`ifdef MEMCTRL_BOUND_CHECK_EN
                        cmd_err_d = 1'b1;
`endif
                    end
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD: begin
                if (!primed_q) begin
                    primed_d = 1'b1;
                end else if (advance) begin
                    rd_data_d  = mem_out;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (cnt_q == CNT_W'(1));
                    mem_add_d  = mem_add + ADDR_W'(1);
                    cnt_d      = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = DRAIN;
                        primed_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (rd_valid && rd_ready) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            mem_add  <= '0;
            mem_in   <= '0;
            mem_read <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
`ifdef MEMCTRL_BOUND_CHECK_EN
            cmd_err  <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            mem_add  <= mem_add_d;
            mem_in   <= mem_in_d;
            mem_read <= mem_read_d;
            rd_data  <= rd_data_d;
            rd_valid <= rd_valid_d;
            rd_last  <= rd_last_d;
`ifdef MEMCTRL_BOUND_CHECK_EN
            cmd_err  <= cmd_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a behavioural 32x8 memory.
module tb_mem_access_ctrl;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_in;
    logic              mem_read;
    logic [DATA_W-1:0] mem_out;
    logic              busy;
`ifdef MEMCTRL_BOUND_CHECK_EN
    logic              cmd_err;
`endif

    logic [DATA_W-1:0] mem [32];
    logic              do_preload;
    int                total;
    int                bad;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_wdata (cmd_wdata),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .mem_add   (mem_add),
        .mem_in    (mem_in),
        .mem_read  (mem_read),
        .mem_out   (mem_out),
        .busy      (busy)
`ifdef MEMCTRL_BOUND_CHECK_EN
        ,
        .cmd_err   (cmd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge when mem_read=1
    assign mem_out = mem[mem_add];
    always @(posedge clk) begin
        if (do_preload) begin
            for (int k = 0; k < 32; k++) mem[k] <= 8'(k);
        end else if (mem_read) begin
            mem[mem_add] <= mem_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                             input logic [ADDR_W-1:0] l, input logic [DATA_W-1:0] d);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; do_preload = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_wdata = '0; rd_ready = 1'b1;
        tick(); tick();
        do_preload = 1'b0;
        total++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin bad++; $display("FAIL reset_rd got valid=%b last=%b want 0 0", rd_valid, rd_last); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
        total++; if (mem_add !== 5'd0 || mem_in !== 8'h00 || mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem got add=%0d in=%h rd=%b want 0 00 0", mem_add, mem_in, mem_read); end
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_state got busy=%b ready=%b want 0 1", busy, cmd_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_then_read();
        rd_ready = 1'b1;
        start_cmd(1'b1, 5'd5, 5'd0, 8'hA5);
        total++; if (mem_read !== 1'b1 || mem_add !== 5'd5 || mem_in !== 8'hA5) begin bad++; $display("FAIL wr_phase got rd=%b add=%0d in=%h want 1 5 a5", mem_read, mem_add, mem_in); end
        total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL wr_busy got busy=%b ready=%b want 1 0", busy, cmd_ready); end
        tick();
        total++; if (mem_read !== 1'b0 || mem_in !== 8'hA5 || cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_done got rd=%b in=%h ready=%b want 0 a5 1", mem_read, mem_in, cmd_ready); end
        total++; if (mem[5] !== 8'hA5) begin bad++; $display("FAIL wr_mem got=%h want=a5", mem[5]); end
        start_cmd(1'b0, 5'd5, 5'd0, 8'h00);
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd1_latency got valid=%b want 0", rd_valid); end
        tick();
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || rd_last !== 1'b1) begin bad++; $display("FAIL rd1_beat got v=%b d=%h l=%b want 1 a5 1", rd_valid, rd_data, rd_last); end
        tick();
        total++; if (rd_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rd1_end got v=%b ready=%b want 0 1", rd_valid, cmd_ready); end
    endtask

    task automatic test_burst();
        rd_ready = 1'b1;
        start_cmd(1'b0, 5'd1, 5'd3, 8'h00);
        total++; if (busy !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL burst_accept got busy=%b v=%b want 1 0", busy, rd_valid); end
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL burst_latency got v=%b want 0", rd_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (rd_valid !== 1'b1 || rd_data !== 8'(i + 1) || rd_last !== (i == 3)) begin bad++; $display("FAIL burst_beat%0d got v=%b d=%0d l=%b want 1 %0d %b", i, rd_valid, rd_data, rd_last, i + 1, i == 3); end
        end
        tick();
        total++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL burst_end got v=%b busy=%b want 0 0", rd_valid, busy); end
    endtask

    task automatic test_stall();
        rd_ready = 1'b1;
        start_cmd(1'b0, 5'd1, 5'd3, 8'h00);
        tick(); tick();
        total++; if (rd_data !== 8'd1 || rd_valid !== 1'b1) begin bad++; $display("FAIL stall_b1 got v=%b d=%0d want 1 1", rd_valid, rd_data); end
        tick();
        total++; if (rd_data !== 8'd2) begin bad++; $display("FAIL stall_b2 got d=%0d want 2", rd_data); end
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (rd_valid !== 1'b1 || rd_data !== 8'd2 || rd_last !== 1'b0 || mem_add !== 5'd3) begin bad++; $display("FAIL stall_hold%0d got v=%b d=%0d l=%b add=%0d want 1 2 0 3", i, rd_valid, rd_data, rd_last, mem_add); end
        end
        rd_ready = 1'b1;
        tick();
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'd3 || rd_last !== 1'b0) begin bad++; $display("FAIL stall_b3 got v=%b d=%0d l=%b want 1 3 0", rd_valid, rd_data, rd_last); end
        tick();
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'd4 || rd_last !== 1'b1) begin bad++; $display("FAIL stall_b4 got v=%b d=%0d l=%b want 1 4 1", rd_valid, rd_data, rd_last); end
        tick();
        total++; if (rd_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL stall_end got v=%b ready=%b want 0 1", rd_valid, cmd_ready); end
    endtask

    task automatic test_wrap();
        rd_ready = 1'b1;
        start_cmd(1'b0, 5'd30, 5'd3, 8'h00);
`ifdef MEMCTRL_BOUND_CHECK_EN
        total++; if (cmd_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL bound_err got err=%b busy=%b want 1 0", cmd_err, busy); end
        tick();
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL bound_pulse got err=%b want 0", cmd_err); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL bound_novalid%0d got v=%b want 0", i, rd_valid); end
        end
`else
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (rd_valid !== 1'b1 || rd_data !== 8'((30 + i) % 32) || rd_last !== (i == 3)) begin bad++; $display("FAIL wrap_beat%0d got v=%b d=%0d l=%b want 1 %0d %b", i, rd_valid, rd_data, rd_last, (30 + i) % 32, i == 3); end
        end
        tick();
        total++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL wrap_end got v=%b busy=%b want 0 0", rd_valid, busy); end
`endif
    endtask

    task automatic test_reset_mid();
        rd_ready = 1'b1;
        start_cmd(1'b0, 5'd8, 5'd7, 8'h00);
        tick(); tick(); tick();
        total++; if (rd_data !== 8'd9) begin bad++; $display("FAIL rst_mid_b2 got d=%0d want 9", rd_data); end
        rst_n = 1'b0;
        #1;
        total++; if (rd_valid !== 1'b0 || mem_read !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_async got v=%b rd=%b busy=%b want 0 0 0", rd_valid, mem_read, busy); end
        total++; if (rd_data !== 8'h00 || mem_add !== 5'd0) begin bad++; $display("FAIL rst_mid_clear got d=%h add=%0d want 00 0", rd_data, mem_add); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_release got ready=%b v=%b want 1 0", cmd_ready, rd_valid); end
        // Reset during the write cycle must suppress the write
        start_cmd(1'b1, 5'd12, 5'd0, 8'h3C);
        rst_n = 1'b0;
        #1;
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL rst_wr_async got rd=%b want 0", mem_read); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (mem[12] !== 8'd12) begin bad++; $display("FAIL rst_wr_mem got=%h want=0c", mem[12]); end
    endtask

    task automatic test_cmd_hold();
        rd_ready = 1'b1;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 5'd1; cmd_len = 5'd1;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL hold_ready%0d got=%b want=0", i, cmd_ready); end
            tick();
        end
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL hold_idle got ready=%b busy=%b want 1 0", cmd_ready, busy); end
        tick();
        cmd_valid = 1'b0;
        total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL hold_accept got busy=%b ready=%b want 1 0", busy, cmd_ready); end
        tick(); tick();
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'd1 || rd_last !== 1'b0) begin bad++; $display("FAIL hold_b1 got v=%b d=%0d l=%b want 1 1 0", rd_valid, rd_data, rd_last); end
        tick();
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'd2 || rd_last !== 1'b1) begin bad++; $display("FAIL hold_b2 got v=%b d=%0d l=%b want 1 2 1", rd_valid, rd_data, rd_last); end
        tick();
        total++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL hold_end got v=%b busy=%b want 0 0", rd_valid, busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_then_read();
        test_burst();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_cmd_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
